// File: rtl/branch_imm_sequencer.sv
// rtl/branch_imm_sequencer.sv - sequencer owning the shared sign extender for branch/jump/immediate resolution
//
// Accepts one decoded instruction at a time, steers the shared 16/26-bit
// extender, resolves branch conditions with a bounded wait, and presents
// either a next-PC redirect or an extended immediate.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready      instruction handshake (ready only in IDLE)
//   instr, pc_plus4              instruction word and its PC+4
//   flush                        abort the in-flight instruction
//   cond_valid, cond_zero        branch comparison result from the ALU
//   sse                          extender mode (00 sext16, 01 sext16<<2, 10 imm26<<2, 11 zero)
//   unextended_16/26             extender inputs
//   extended                     extender result (combinational)
//   out_valid/out_ready          result handshake
//   redirect, next_pc            resolved next PC
//   imm_out                      extended immediate for I-type
//   link                         JAL writes pc_plus4 to $31
//   error                        branch resolved by timeout

module branch_imm_sequencer #(
    parameter int COND_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    input  logic        flush,
    input  logic        cond_valid,
    input  logic        cond_zero,
    output logic [1:0]  sse,
    output logic [15:0] unextended_16,
    output logic [25:0] unextended_26,
    input  logic [31:0] extended,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic [31:0] imm_out,
    output logic        link,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXTEND = 2'd1,
        S_COND   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [2:0] C_BEQ   = 3'd0;
    localparam logic [2:0] C_BNE   = 3'd1;
    localparam logic [2:0] C_J     = 3'd2;
    localparam logic [2:0] C_JAL   = 3'd3;
    localparam logic [2:0] C_RTYPE = 3'd4;
    localparam logic [2:0] C_IMM   = 3'd5;

    localparam logic [1:0] SSE_SEXT16   = 2'b00;
    localparam logic [1:0] SSE_SEXT16S2 = 2'b01;
    localparam logic [1:0] SSE_IMM26S2  = 2'b10;
    localparam logic [1:0] SSE_ZERO     = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(COND_TIMEOUT - 1);

    function automatic logic [2:0] classify(input logic [5:0] opcode);
        case (opcode)
            6'b000100: classify = C_BEQ;
            6'b000101: classify = C_BNE;
            6'b000010: classify = C_J;
            6'b000011: classify = C_JAL;
            6'b000000: classify = C_RTYPE;
            default:   classify = C_IMM;
        endcase
    endfunction

    state_t      state, state_nxt;
    logic [25:0] instr_q;
    logic [31:0] pc_q;
    logic [2:0]  cls_q;
    logic [31:0] ext_q;
    logic [7:0]  cnt;

    logic        is_branch;
    logic        timeout;
    logic [31:0] ext_src;
    logic        cond_taken;
    logic [31:0] res_next_pc;
    logic [31:0] res_imm;
    logic        res_redirect;
    logic        res_link;
    logic        res_error;

    assign is_branch = (cls_q == C_BEQ) || (cls_q == C_BNE);
    assign timeout   = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush beats cond_valid and timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) state_nxt = S_EXTEND;
            end
            S_EXTEND: begin
                if (flush)          state_nxt = S_IDLE;
                else if (is_branch) state_nxt = S_COND;
                else                state_nxt = S_RESULT;
            end
            S_COND: begin
                if (flush)                      state_nxt = S_IDLE;
                else if (cond_valid || timeout) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (flush || out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: extender steering and input handshake
    always_comb begin
        instr_ready   = (state == S_IDLE);
        sse           = SSE_ZERO;
        unextended_16 = '0;
        unextended_26 = '0;
        if (state == S_EXTEND) begin
            unextended_16 = instr_q[15:0];
            unextended_26 = instr_q;
            case (cls_q)
                C_BEQ, C_BNE: sse = SSE_SEXT16S2;
                C_J, C_JAL:   sse = SSE_IMM26S2;
                C_IMM:        sse = SSE_SEXT16;
                default:      sse = SSE_ZERO;
            endcase
        end
    end

    // Result computation. Non-branches load their result at the end of
    // EXTEND, when ext_q is still being written, so they use the live
    // extender output instead of the registered copy.
    always_comb begin
        ext_src      = (state == S_EXTEND) ? extended : ext_q;
        cond_taken   = cond_valid && ((cls_q == C_BEQ) ? cond_zero : !cond_zero);
        res_next_pc  = pc_q;
        res_imm      = imm_out;
        res_redirect = 1'b0;
        res_link     = 1'b0;
        res_error    = 1'b0;
        case (cls_q)
            C_BEQ, C_BNE: begin
                if (cond_taken) begin
                    res_next_pc  = pc_q + ext_src;
                    res_redirect = 1'b1;
                end
                // Only reached on cond_valid or timeout, so no cond_valid means timeout
                res_error = !cond_valid;
            end
            C_J, C_JAL: begin
                res_next_pc  = {pc_q[31:28], ext_src[27:0]};
                res_redirect = 1'b1;
                res_link     = (cls_q == C_JAL);
            end
            C_IMM:   res_imm = ext_src;
            default: res_imm = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q   <= '0;
            pc_q      <= '0;
            cls_q     <= C_RTYPE;
            ext_q     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            redirect  <= 1'b0;
            link      <= 1'b0;
            error     <= 1'b0;
            next_pc   <= '0;
            imm_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr[25:0];
                        pc_q    <= pc_plus4;
                        cls_q   <= classify(instr[31:26]);
                    end
                end
                S_EXTEND: begin
                    ext_q <= extended;
                    cnt   <= '0;
                    if (!flush && !is_branch) begin
                        out_valid <= 1'b1;
                        next_pc   <= res_next_pc;
                        imm_out   <= res_imm;
                        redirect  <= res_redirect;
                        link      <= res_link;
                        error     <= res_error;
                    end
                end
                S_COND: begin
                    if (!flush) begin
                        if (cond_valid || timeout) begin
                            out_valid <= 1'b1;
                            next_pc   <= res_next_pc;
                            imm_out   <= res_imm;
                            redirect  <= res_redirect;
                            link      <= res_link;
                            error     <= res_error;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        redirect  <= 1'b0;
                        link      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_imm_sequencer.sv
// tb/tb_branch_imm_sequencer.sv - scoreboard bench for branch_imm_sequencer

module tb_branch_imm_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        cond_valid;
    logic        cond_zero;
    logic [1:0]  sse;
    logic [15:0] unextended_16;
    logic [25:0] unextended_26;
    logic [31:0] extended;
    logic        out_valid;
    logic        out_ready;
    logic        redirect;
    logic [31:0] next_pc;
    logic [31:0] imm_out;
    logic        link;
    logic        error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] imm;
        logic        redir;
        logic        lnk;
        logic        err;
        logic        chk_imm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Shared extender model
    always_comb begin
        case (sse)
            2'b00:   extended = {{16{unextended_16[15]}}, unextended_16};
            2'b01:   extended = {{14{unextended_16[15]}}, unextended_16, 2'b00};
            2'b10:   extended = {4'b0000, unextended_26, 2'b00};
            default: extended = 32'h0;
        endcase
    end

    branch_imm_sequencer #(.COND_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc_plus4(pc_plus4), .flush(flush),
        .cond_valid(cond_valid), .cond_zero(cond_zero),
        .sse(sse), .unextended_16(unextended_16), .unextended_26(unextended_26),
        .extended(extended),
        .out_valid(out_valid), .out_ready(out_ready),
        .redirect(redirect), .next_pc(next_pc), .imm_out(imm_out),
        .link(link), .error(error)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] npc, input logic [31:0] imm,
                        input logic redir, input logic lnk, input logic err, input logic chk_imm);
        exp_t e;
        e.npc = npc; e.imm = imm; e.redir = redir; e.lnk = lnk; e.err = err; e.chk_imm = chk_imm;
        sb.push_back(e);
    endtask

    // Offer an instruction in IDLE and land in EXTEND
    task automatic issue(input logic [31:0] i, input logic [31:0] pc,
                         input logic [1:0] exp_sse, input string nm);
        instr = i; pc_plus4 = pc; instr_valid = 1'b1;
        check({nm, "_ready"}, instr_ready, 1);
        step;
        instr_valid = 1'b0;
        check({nm, "_sse"}, sse, exp_sse);
        check({nm, "_ext_ovalid"}, out_valid, 0);
    endtask

    task automatic run_simple(input logic [31:0] i, input logic [31:0] pc,
                              input logic [1:0] exp_sse, input string nm);
        issue(i, pc, exp_sse, nm);
        step;
        check({nm, "_latency"}, out_valid, 1);
        step;
    endtask

    task automatic run_branch(input logic [31:0] i, input logic [31:0] pc,
                              input int wait_cyc, input logic zero, input string nm);
        issue(i, pc, 2'b01, nm);
        step;
        for (int k = 0; k < wait_cyc; k++) begin
            check({nm, "_wait_ovalid"}, out_valid, 0);
            step;
        end
        cond_valid = 1'b1; cond_zero = zero;
        step;
        cond_valid = 1'b0;
        check({nm, "_latency"}, out_valid, 1);
        step;
    endtask

    // Monitor: pops the scoreboard on every accepted result
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_next_pc", next_pc, e.npc);
                    check("mon_redirect", redirect, e.redir);
                    check("mon_link", link, e.lnk);
                    check("mon_error", error, e.err);
                    if (e.chk_imm) check("mon_imm_out", imm_out, e.imm);
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0; instr_valid = 1'b0; instr = '0; pc_plus4 = '0;
        flush = 1'b0; cond_valid = 1'b0; cond_zero = 1'b0; out_ready = 1'b1;
        step; step;
        check("rst_out_valid", out_valid, 0);
        check("rst_sse", sse, 2'b11);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_next_pc", next_pc, 0);
        check("rst_imm_out", imm_out, 0);
        check("rst_unext16", unextended_16, 0);
        reset_n = 1'b1;
        step;

        push(32'h0040000C, 0, 1, 0, 0, 0);
        run_branch(32'h1000FFFF, 32'h00400010, 0, 1'b1, "beq_taken");
        push(32'h00400020, 0, 0, 0, 0, 0);
        run_branch(32'h14000004, 32'h00400020, 0, 1'b1, "bne_not_taken");
        push(32'h00400038, 0, 1, 0, 0, 0);
        run_branch(32'h1400FFFE, 32'h00400040, 3, 1'b0, "bne_taken_late");
        push(32'h10400010, 0, 1, 1, 0, 0);
        run_simple(32'h0C100004, 32'h10000008, 2'b10, "jal");
        push(32'hA0000040, 0, 1, 0, 0, 0);
        run_simple(32'h08000010, 32'hA0000004, 2'b10, "j");
        push(32'h00400004, 32'h0, 0, 0, 0, 1);
        run_simple(32'h012A4020, 32'h00400004, 2'b11, "rtype");

        // ADDI held by back-pressure
        out_ready = 1'b0;
        push(32'h00400008, 32'hFFFF8000, 0, 0, 0, 1);
        issue(32'h20088000, 32'h00400008, 2'b00, "addi");
        step;
        instr_valid = 1'b1; instr = 32'h10000000;
        for (int k = 0; k < 5; k++) begin
            check("hold_instr_ready", instr_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_imm_out", imm_out, 32'hFFFF8000);
            check("hold_next_pc", next_pc, 32'h00400008);
            step;
        end
        instr_valid = 1'b0; out_ready = 1'b1;
        step;
        check("hold_release_ready", instr_ready, 1);

        // Condition timeout
        push(32'h00400100, 0, 0, 0, 1, 0);
        out_ready = 1'b0;
        issue(32'h10000003, 32'h00400100, 2'b01, "timeout");
        step;
        n = 0;
        while (!out_valid && n < 40) begin
            n++;
            step;
        end
        check("timeout_cond_cycles", n, 15);
        cond_valid = 1'b1; cond_zero = 1'b1;
        step;
        cond_valid = 1'b0;
        check("timeout_hold_valid", out_valid, 1);
        check("timeout_error", error, 1);
        check("timeout_redirect", redirect, 0);
        check("timeout_next_pc", next_pc, 32'h00400100);
        out_ready = 1'b1;
        step;

        // Flush in COND
        issue(32'h1000FFFF, 32'h00400010, 2'b01, "flush");
        step;
        flush = 1'b1;
        step;
        flush = 1'b0;
        check("flush_idle", instr_ready, 1);
        check("flush_ovalid", out_valid, 0);
        cond_valid = 1'b1; cond_zero = 1'b1;
        step;
        cond_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("flush_no_result", out_valid, 0);
            step;
        end

        // Reset in RESULT
        out_ready = 1'b0;
        issue(32'h0C100004, 32'h10000008, 2'b10, "rst_result");
        step;
        check("rst_result_valid", out_valid, 1);
        check("rst_result_link", link, 1);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_redirect", redirect, 0);
        check("arst_link", link, 0);
        check("arst_next_pc", next_pc, 0);
        check("arst_sse", sse, 2'b11);
        check("arst_unext26", unextended_26, 0);
        step;
        reset_n = 1'b1; out_ready = 1'b1;
        step;

        push(32'h00400200, 32'h00007FFF, 0, 0, 0, 1);
        run_simple(32'h20087FFF, 32'h00400200, 2'b00, "addi_pos");

        step;
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
